// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART blocks.
//   parity_e   - run-time parity selection encoding (3 is reserved, treated as none)
//   tx_state_e - transmitter FSM states
//   calc_div   - clock cycles per bit, integer-truncated
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: send/ready handshake between the command formatter and the
// UART transmitter.
//   send, data, parity_mode, stop2 : formatter -> transmitter
//   ready, done                    : transmitter -> formatter
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 send;
  logic [DATA_BITS-1:0] data;
  logic [1:0]           parity_mode;
  logic                 stop2;
  logic                 ready;
  logic                 done;

  modport master (
    output send, data, parity_mode, stop2,
    input  ready, done
  );

  modport slave (
    input  send, data, parity_mode, stop2,
    output ready, done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period timer counting 0..DIV-1 while enabled.
//   clock, reset_n : clock and async active-low reset
//   clear          : forces the count to 0 (wins over enable)
//   enable         : count this cycle
//   bit_end        : high in the cycle where the count sits at DIV-1 while enabled
module uart_bit_timer #(
  parameter int unsigned DIV = 2604
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign bit_end = enable && (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with run-time parity and stop-bit
// selection, sampled once per frame on accept (send && ready).
//   clock, reset_n : clock and async active-low reset
//   bus            : send/data/parity_mode/stop2 in, ready/done out
//   brk            : line break request (only with UART_TX_BREAK_EN defined)
//   tx             : registered serial line, idle high
//
// state  | meaning
// IDLE   | line high, ready for a new frame
// START  | start bit (low) for one bit period
// DATA   | DATA_BITS payload bits, LSB first
// PARITY | parity bit for one bit period (skipped when parity is off)
// STOP   | one or two stop bit periods, done pulses at the end
// BREAK  | line held low while brk, then one high bit period (UART_TX_BREAK_EN)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  uart_tx_cfg_if.slave bus,
`ifdef UART_TX_BREAK_EN
  input  logic         brk,
`endif
  output logic         tx
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD_RATE);
  localparam int          CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_tx_cfg: DATA_BITS must be within 5..9");
    end
  endgenerate

  tx_state_e            state, state_nxt;
  logic                 tx_q, tx_nxt;
  logic                 ready_q, ready_nxt;
  logic                 done_q, done_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 par_en, par_en_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 stop2_q, stop2_nxt;
  logic                 tmr_clear, tmr_en, bit_end;

  assign tx        = tx_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign tmr_en    = (state != IDLE);

  uart_bit_timer #(.DIV(DIV)) u_bit_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .bit_end (bit_end)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_q    <= tx_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_en  <= par_en_nxt;
      par_bit <= par_bit_nxt;
      stop2_q <= stop2_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tx_nxt      = tx_q;
    ready_nxt   = ready_q;
    done_nxt    = 1'b0;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_en_nxt  = par_en;
    par_bit_nxt = par_bit;
    stop2_nxt   = stop2_q;
    tmr_clear   = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          state_nxt = BREAK;
          tx_nxt    = 1'b0;
          ready_nxt = 1'b0;
        end else
`endif
        if (bus.send && ready_q) begin
          state_nxt   = START;
          tx_nxt      = 1'b0;
          ready_nxt   = 1'b0;
          shreg_nxt   = bus.data;
          bit_cnt_nxt = '0;
          par_en_nxt  = (bus.parity_mode == PAR_EVEN) || (bus.parity_mode == PAR_ODD);
          par_bit_nxt = (bus.parity_mode == PAR_ODD) ? ~^bus.data : ^bus.data;
          stop2_nxt   = bus.stop2;
          tmr_clear   = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          tx_nxt      = shreg[0];
          shreg_nxt   = {1'b0, shreg[DATA_BITS-1:1]};
          bit_cnt_nxt = CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt   = par_en ? PARITY : STOP;
            tx_nxt      = par_en ? par_bit : 1'b1;
            bit_cnt_nxt = '0;
          end else begin
            tx_nxt      = shreg[0];
            shreg_nxt   = {1'b0, shreg[DATA_BITS-1:1]};
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          tx_nxt      = 1'b1;
          bit_cnt_nxt = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          // bit_cnt doubles as the stop-bit counter here
          if (stop2_q && bit_cnt == '0) begin
            bit_cnt_nxt = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            ready_nxt = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        // tx_q low marks the hold phase; the timer stays cleared until the
        // cycle the line goes high so the recovery lasts a full bit period
        if (!tx_q) begin
          tmr_clear = 1'b1;
          if (!brk) tx_nxt = 1'b1;
        end else if (bit_end) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DB     = 8;
  localparam int          DIV    = 10;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tx;
`ifdef UART_TX_BREAK_EN
  logic brk = 1'b0;
`endif

  uart_tx_cfg_if #(.DATA_BITS(DB)) bus ();

  uart_tx_cfg #(
    .CLK_HZ    (CLK_HZ),
    .BAUD_RATE (BAUD),
    .DATA_BITS (DB)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
`ifdef UART_TX_BREAK_EN
    .brk     (brk),
`endif
    .tx      (tx)
  );

  always #5 clock = ~clock;

  // frame: expected line level per bit period, index 0 = start bit
  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pmode;
    logic        stop2;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[7];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called 1ns after the accept edge; leaves off 1ns after the done edge.
  task automatic check_frame(input logic [11:0] frame, input int nbits, input bit poke);
    for (int i = 0; i < nbits * DIV; i++) begin
      check($sformatf("tx_cyc%0d", i), {31'd0, tx}, {31'd0, frame[i / DIV]});
      check($sformatf("ready_busy%0d", i), {31'd0, bus.ready}, 32'd0);
      check($sformatf("done_busy%0d", i), {31'd0, bus.done}, 32'd0);
      if (poke && i == 43) begin
        bus.send        = 1'b1;
        bus.data        = 8'h3C;
        bus.parity_mode = 2'd2;
        bus.stop2       = 1'b1;
      end
      if (poke && i == 44) bus.send = 1'b0;
      step();
    end
    check("done_end", {31'd0, bus.done}, 32'd1);
    check("ready_end", {31'd0, bus.ready}, 32'd1);
    check("tx_end", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_seen;

    vecs[0] = '{8'hA5, 2'd0, 1'b0, 10, 12'h34A};
    vecs[1] = '{8'h03, 2'd1, 1'b0, 11, 12'h406};
    vecs[2] = '{8'h03, 2'd2, 1'b0, 11, 12'h606};
    vecs[3] = '{8'h5A, 2'd0, 1'b1, 11, 12'h6B4};
    vecs[4] = '{8'hFF, 2'd2, 1'b0, 11, 12'h7FE};
    vecs[5] = '{8'h00, 2'd3, 1'b1, 11, 12'h600};
    vecs[6] = '{8'h80, 2'd1, 1'b1, 12, 12'hF00};

    bus.send        = 1'b0;
    bus.data        = '0;
    bus.parity_mode = 2'd0;
    bus.stop2       = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset_n = 1'b1;
    step();

    // table-driven frames, inputs scrambled after accept and a mid-frame send poke
    foreach (vecs[v]) begin
      bus.data        = vecs[v].data;
      bus.parity_mode = vecs[v].pmode;
      bus.stop2       = vecs[v].stop2;
      bus.send        = 1'b1;
      step();
      bus.send        = 1'b0;
      bus.data        = ~vecs[v].data;
      bus.parity_mode = ~vecs[v].pmode;
      bus.stop2       = ~vecs[v].stop2;
      check_frame(vecs[v].frame, vecs[v].nbits, 1'b1);
      step();
      check("idle_done_low", {31'd0, bus.done}, 32'd0);
      check("idle_ready", {31'd0, bus.ready}, 32'd1);
      check("idle_tx", {31'd0, tx}, 32'd1);
    end

    // back-to-back with send held high, two stop bits
    bus.data        = 8'h55;
    bus.parity_mode = 2'd0;
    bus.stop2       = 1'b1;
    bus.send        = 1'b1;
    step();
    bus.data = 8'hAA;
    check_frame(12'h6AA, 11, 1'b0);
    step();
    check_frame(12'h754, 11, 1'b0);
    bus.send = 1'b0;
    step();
    check("b2b_idle_ready", {31'd0, bus.ready}, 32'd1);

    // reset in the middle of a frame
    bus.data        = 8'hA5;
    bus.parity_mode = 2'd0;
    bus.stop2       = 1'b0;
    bus.send        = 1'b1;
    step();
    bus.send = 1'b0;
    repeat (45) step();
    check("pre_rst_busy", {31'd0, bus.ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_ready", {31'd0, bus.ready}, 32'd1);
    check("async_rst_done", {31'd0, bus.done}, 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (bus.done || !tx) done_seen = 1'b1;
    end
    check("no_done_after_rst", {31'd0, done_seen}, 32'd0);
    bus.send = 1'b1;
    step();
    bus.send = 1'b0;
    check_frame(12'h34A, 10, 1'b0);
    step();

`ifdef UART_TX_BREAK_EN
    // break with a concurrent send that must not be accepted
    brk      = 1'b1;
    bus.send = 1'b1;
    bus.data = 8'h00;
    step();
    bus.send = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check($sformatf("brk_low%0d", i), {31'd0, tx}, 32'd0);
      check($sformatf("brk_ready%0d", i), {31'd0, bus.ready}, 32'd0);
      if (i == 49) brk = 1'b0;
      step();
    end
    for (int i = 0; i < DIV; i++) begin
      check($sformatf("brk_rec_tx%0d", i), {31'd0, tx}, 32'd1);
      check($sformatf("brk_rec_ready%0d", i), {31'd0, bus.ready}, 32'd0);
      check($sformatf("brk_rec_done%0d", i), {31'd0, bus.done}, 32'd0);
      step();
    end
    check("brk_end_ready", {31'd0, bus.ready}, 32'd1);
    check("brk_end_done", {31'd0, bus.done}, 32'd0);
    check("brk_end_tx", {31'd0, tx}, 32'd1);
    step();
    check("brk_no_frame", {31'd0, tx}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that succeeds the fixed 9-bit, 9600-baud TX.
- Data width, clock and baud rate are compile-time parameters.
- Parity mode and stop-bit count are selected at run time, sampled per frame.
- Has an internal bit-period timer; the shared baud generator is not used.
- Sits between the ATC command formatter and the board serial pin, with a send/ready handshake and a per-frame done pulse.

Parameters:
CLK_HZ, 25_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits/s
DATA_BITS, 8, payload bits per frame, legal range 5..9 (elaborate-time assertion outside this range)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
send  in  1  request to transmit data; accepted only when ready=1
data  in  DATA_BITS  payload, captured on the accept cycle
parity_mode  in  2  0=none, 1=even, 2=odd, 3=none (reserved); captured on accept
stop2  in  1  1 = two stop bits, 0 = one; captured on accept
tx  out  1  serial line, idle high
ready  out  1  high when idle and able to accept
done  out  1  one-cycle pulse when the final stop bit period ends

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values: tx=1, ready=1, done=0, state IDLE, all counters 0.
- Reset mid-frame: the line returns high immediately and the frame is abandoned; no done pulse.
- Bit period: DIV = CLK_HZ/BAUD_RATE, integer-truncated; 2604 at the defaults.
  - Timer counts 0..DIV-1; a bit boundary is timer==DIV-1.
  - Timer width is $clog2(DIV).
  - Timer is cleared on accept.
- Accept: the cycle where send && ready.
  - Registers data, parity_mode and stop2.
  - Computes parity = ^data for even, ~^data for odd.
  - Inputs changing after accept have no effect on the frame in flight.
- Latency: tx goes low on the cycle after accept; ready=0 from the cycle after accept.
- States:
  - IDLE: tx=1, ready=1. On accept -> START.
  - START: tx=0 for DIV cycles -> DATA.
  - DATA: DATA_BITS periods, LSB first, via shift register and bit counter ($clog2(DATA_BITS+1) bits). After the last bit -> PARITY if parity is enabled, else STOP.
  - PARITY: tx=parity bit for one period -> STOP.
  - STOP: tx=1 for 1 or 2 periods as set by stop2. At the end: done=1 for one cycle, ready=1 on the same cycle, -> IDLE.
- Back-to-back: send held high while done pulses is accepted on the next cycle, when ready=1.
  - Inter-frame gap is 0 extra bit periods beyond the stop bits, apart from the single IDLE cycle.
- send while ready=0 is ignored, with no queuing.
- The tx output is registered with no combinational path from inputs; done and ready are registered.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input port brk (1 bit).
  - brk=1 in IDLE enters state BREAK: tx=0, ready=0, held while brk=1.
  - On brk deassertion, tx=1 is held for one full bit period, then -> IDLE with ready=1 and no done pulse.
  - brk arriving during a frame is ignored until IDLE.
  - brk and send both high in IDLE: brk wins, and the send is not accepted.
- Not defined: no brk port, no BREAK state; behaviour is exactly as above.

Decomposition:
- Package uart_pkg: enum parity_e {PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2}; typedef tx_state_e {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - uart_pkg also holds the function calc_div(clk_hz, baud) for the future RX.
- One sub-module: uart_bit_timer, parameter DIV, inputs clear/enable, output bit_end pulse. The FSM and datapath stay in uart_tx_cfg.

Test Plan:
Bench parameters: CLK_HZ=1_000_000, BAUD_RATE=100_000 (DIV=10), DATA_BITS=8.
1. data=8'hA5, parity none, stop2=0, send pulse -> tx low for 10 cycles starting 1 cycle after accept, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles; done at cycle 100 after accept; ready low in between.
2. data=8'h03, even parity -> parity bit 0; same data, odd parity -> parity bit 1; frame length 110 cycles.
3. stop2=1, send held high continuously with data 8'h55 then 8'hAA -> second start bit begins 1 cycle after the first done; first frame 110 cycles.
4. reset_n low at cycle 45 of a frame -> tx=1 and ready=1 asynchronously, no done; a new send after release gives a clean frame.
5. send pulsed and data changed during a frame -> ignored; the transmitted byte equals the value at accept.
6. With UART_TX_BREAK_EN: brk high 50 cycles in IDLE -> tx low 50 cycles, then high 10 cycles with ready=0, then ready=1; send concurrent with brk is not accepted.
